// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor
//   LSB-first bit-serial subtractor. It computes diff = a - b one bit per clock,
//   using a single full-subtract cell and a registered borrow flop.
//   A run takes exactly WIDTH SHIFT cycles, followed by one DONE cycle.
//
// Optional feature: define BSUB_ADD_MODE_EN to add the bsub_mode port.
//   mode=0 : subtract
//   mode=1 : add (A+B). bsub_borrow then carries the carry-out.
//   Timing is identical in both builds.
//
// Ports
//   bsub_clk     in   1      system clock, rising edge
//   bsub_rst_n   in   1      async active-low reset
//   bsub_start   in   1      request, accepted only in IDLE
//   bsub_mode    in   1      0=sub, 1=add (BSUB_ADD_MODE_EN builds only)
//   bsub_a       in   WIDTH  minuend, sampled on accept
//   bsub_b       in   WIDTH  subtrahend, sampled on accept
//   bsub_busy    out  1      high while in SHIFT
//   bsub_done    out  1      one-cycle pulse, result valid
//   bsub_diff    out  WIDTH  result register
//   bsub_borrow  out  1      final borrow (unsigned a<b) / carry-out in add mode
//   bsub_ovf     out  1      signed two's-complement overflow

// One-bit full subtract / full add cell.
//   The sum bit is the same for both operations.
//   Only the borrow/carry term differs.
module bsub_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic add,
  output logic d,
  output logic c_next
);
  logic br_n, cy_n;

  assign d      = a ^ b ^ c;
  assign br_n   = (~a & b) | (~(a ^ b) & c);
  assign cy_n   = (a & b) | (a & c) | (b & c);
  assign c_next = add ? cy_n : br_n;
endmodule

module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             bsub_clk,
  input  logic             bsub_rst_n,
  input  logic             bsub_start,
`ifdef BSUB_ADD_MODE_EN
  input  logic             bsub_mode,
`endif
  input  logic [WIDTH-1:0] bsub_a,
  input  logic [WIDTH-1:0] bsub_b,
  output logic             bsub_busy,
  output logic             bsub_done,
  output logic [WIDTH-1:0] bsub_diff,
  output logic             bsub_borrow,
  output logic             bsub_ovf
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             br_q;
  logic [CNT_W-1:0] cnt;
  logic             add_sel;

  logic             cell_d, cell_cn;
  logic             accept, last_bit;
  logic             ovf_fin;

`ifdef BSUB_ADD_MODE_EN
  logic mode_q;

  always_ff @(posedge bsub_clk or negedge bsub_rst_n) begin
    if (!bsub_rst_n)                          mode_q <= 1'b0;
    else if (state == S_IDLE && bsub_start)   mode_q <= bsub_mode;
  end

  assign add_sel = mode_q;
`else
  assign add_sel = 1'b0;
`endif

  assign accept   = (state == S_IDLE) && bsub_start;
  assign last_bit = (state == S_SHIFT) && (cnt == CNT_W'(WIDTH - 1));

  bsub_cell u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .c      (br_q),
    .add    (add_sel),
    .d      (cell_d),
    .c_next (cell_cn)
  );

  // On the last bit, a_sr[0]/b_sr[0] hold the original operand MSBs.
  //   Sub overflows when the signs differ and the result sign flips away from a.
  //   Add overflows when the signs match and the result sign differs from a.
  always_comb begin
    ovf_fin = 1'b0;
    if (add_sel) ovf_fin = ~(a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
    else         ovf_fin =  (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
  end

  // DONE always returns to IDLE, so a start held high in DONE is not queued.
  always_ff @(posedge bsub_clk or negedge bsub_rst_n) begin
    if (!bsub_rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bsub_start) state <= S_SHIFT;
        S_SHIFT: if (last_bit)   state <= S_DONE;
        S_DONE:                  state <= S_IDLE;
        default:                 state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand shift registers, borrow flop and bit counter.
  always_ff @(posedge bsub_clk or negedge bsub_rst_n) begin
    if (!bsub_rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      br_q <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= bsub_a;
      b_sr <= bsub_b;
      br_q <= 1'b0;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br_q <= cell_cn;
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers.
  //   diff fills from the MSB end, so after WIDTH shifts bit 0 holds result bit 0.
  //   borrow/ovf clear on accept and load on the final bit.
  always_ff @(posedge bsub_clk or negedge bsub_rst_n) begin
    if (!bsub_rst_n) begin
      bsub_diff   <= '0;
      bsub_borrow <= 1'b0;
      bsub_ovf    <= 1'b0;
    end else if (accept) begin
      bsub_borrow <= 1'b0;
      bsub_ovf    <= 1'b0;
    end else if (state == S_SHIFT) begin
      bsub_diff <= {cell_d, bsub_diff[WIDTH-1:1]};
      if (last_bit) begin
        bsub_borrow <= cell_cn;
        bsub_ovf    <= ovf_fin;
      end
    end
  end

  assign bsub_busy = (state == S_SHIFT);
  assign bsub_done = (state == S_DONE);
endmodule

// File: tb/tb_bit_serial_subtractor.sv
module tb_bit_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .bsub_clk    (clk),
    .bsub_rst_n  (rst_n),
    .bsub_start  (start),
`ifdef BSUB_ADD_MODE_EN
    .bsub_mode   (mode),
`endif
    .bsub_a      (a),
    .bsub_b      (b),
    .bsub_busy   (busy),
    .bsub_done   (done),
    .bsub_diff   (diff),
    .bsub_borrow (borrow),
    .bsub_ovf    (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int sgn(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Reference model: plain integer arithmetic, no bit-level detail.
  task automatic model(input logic [W-1:0] ia, ib, input logic im,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int r, sr;
    if (im) begin
      r  = int'(ia) + int'(ib);
      sr = sgn(ia) + sgn(ib);
      eb = (r >= (1 << W));
    end else begin
      r  = int'(ia) - int'(ib);
      sr = sgn(ia) - sgn(ib);
      eb = (ia < ib);
    end
    ed = W'(r & ((1 << W) - 1));
    eo = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
  endtask

  // Starts an operation and returns at the negedge where done is seen.
  // Operands are scrambled after the accept edge; they must not affect the result.
  task automatic run_op(input logic [W-1:0] ia, ib, input logic im,
                        output int nbusy, output int dcyc);
    @(negedge clk);
    a = ia; b = ib; mode = im; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    mode = ~im;
    nbusy = 0;
    dcyc = 0;
    for (int c = 1; c <= 3*W; c++) begin
      if (busy) nbusy++;
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ia, ib, input logic im,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
    int nb, dc;
    run_op(ia, ib, im, nb, dc);
    chk({name, ".busy_cycles"}, nb, W);
    chk({name, ".done_cycle"}, dc, W + 1);
    chk({name, ".diff"}, diff, ed);
    chk({name, ".borrow"}, borrow, eb);
    chk({name, ".ovf"}, ovf, eo);
    @(negedge clk);
    chk({name, ".done_pulse_end"}, done, 0);
    chk({name, ".diff_hold"}, diff, ed);
  endtask

  initial begin
    logic [W-1:0] ed;
    logic         eb, eo;
    logic [W-1:0] ra, rb;
    logic         rm;
    int           pulses;
    logic [W-1:0] seen;

    tbl[0] = '{a: 8'd100,  b: 8'd37,   m: 1'b0, d: 8'd63,   br: 1'b0, ov: 1'b0};
    tbl[1] = '{a: 8'd5,    b: 8'd10,   m: 1'b0, d: 8'hFB,   br: 1'b1, ov: 1'b0};
    tbl[2] = '{a: 8'h5A,   b: 8'h5A,   m: 1'b0, d: 8'h00,   br: 1'b0, ov: 1'b0};
    tbl[3] = '{a: 8'h80,   b: 8'h01,   m: 1'b0, d: 8'h7F,   br: 1'b0, ov: 1'b1};
    tbl[4] = '{a: 8'h7F,   b: 8'hFF,   m: 1'b0, d: 8'h80,   br: 1'b1, ov: 1'b1};
    tbl[5] = '{a: 8'h00,   b: 8'hFF,   m: 1'b0, d: 8'h01,   br: 1'b1, ov: 1'b0};
    tbl[6] = '{a: 8'hFF,   b: 8'h00,   m: 1'b0, d: 8'hFF,   br: 1'b0, ov: 1'b0};

    // Reset state.
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 0);
    chk("rst.borrow", borrow, 0);
    chk("rst.ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].m,
               tbl[i].d, tbl[i].br, tbl[i].ov);

    // A start re-pulsed mid-run is ignored: one done pulse, and the first result is kept.
    @(negedge clk);
    a = 8'd100; b = 8'd37; mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'd1; b = 8'd1;
    @(negedge clk); start = 1'b0;
    pulses = 0;
    seen = '0;
    for (int c = 0; c < 3*W; c++) begin
      if (done) begin
        pulses++;
        seen = diff;
      end
      @(negedge clk);
    end
    chk("restart.pulses", pulses, 1);
    chk("restart.diff", seen, 63);
    chk("restart.busy_after", busy, 0);

    // A start held during the DONE cycle is not queued.
    begin
      int nb, dc;
      run_op(8'd9, 8'd4, 1'b0, nb, dc);
      chk("done_start.diff", diff, 5);
      start = 1'b1; a = 8'd3; b = 8'd1;
      @(negedge clk); start = 1'b0;
      chk("done_start.busy", busy, 0);
      chk("done_start.done", done, 0);
      @(negedge clk);
      chk("done_start.busy2", busy, 0);
      chk("done_start.hold", diff, 5);
    end

    // Reset in SHIFT cycle 4 aborts at once; no done pulse follows.
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.diff", diff, 0);
    chk("abort.borrow", borrow, 0);
    chk("abort.ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort.no_activity", pulses, 0);
    check_op("abort.clean", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);

`ifdef BSUB_ADD_MODE_EN
    check_op("add0", 8'd200, 8'd100, 1'b1, 8'd44, 1'b1, 1'b0);
    check_op("add1", 8'h40, 8'h40, 1'b1, 8'h80, 1'b0, 1'b1);
`endif

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef BSUB_ADD_MODE_EN
      rm = 1'($urandom);
`else
      rm = 1'b0;
`endif
      model(ra, rb, rm, ed, eb, eo);
      check_op($sformatf("rnd%0d", i), ra, rb, rm, ed, eb, eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
